// File: rtl/cmd_exec_sync.sv
// cmd_exec_sync: command-consumer end of the command-memory link.
// Arms one command per DATA_WR, launches the impulse burst
// (BLANK1 -> PULSE -> BLANK2 -> PAUSE, repeated N times) once TIME reaches
// TIME_START, then requests the next command with a REQ_LEN-cycle REQ_COMM.
// Optional feature macro: CMD_EXEC_CHIRP_EN enables the TYPE 1/2 frequency sweep.
// Without it FREQ_OUT is the plain FREQ word for the whole pulse.
module cmd_exec_sync #(
    parameter int REQ_LEN = 4
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [63:0] TIME,
    input  logic        DATA_WR,
    input  logic [47:0] FREQ,
    input  logic [47:0] FREQ_STEP,
    input  logic [31:0] FREQ_RATE,
    input  logic [63:0] TIME_START,
    input  logic [15:0] N_impulse,
    input  logic [1:0]  TYPE_impulse,
    input  logic [31:0] Interval_Ti,
    input  logic [31:0] Interval_Tp,
    input  logic [31:0] Tblank1,
    input  logic [31:0] Tblank2,
    output logic        GATE,
    output logic        BLANK,
    output logic [47:0] FREQ_OUT,
    output logic        REQ_COMM,
    output logic        BUSY,
    output logic        LATE,
    output logic [15:0] IMP_CNT
);

    // Phase states carry bit 2 set so the low two bits are the phase index
    // in impulse order (0=BLANK1, 1=PULSE, 2=BLANK2, 3=PAUSE).
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        REQ    = 3'd2,
        BLANK1 = 3'd4,
        PULSE  = 3'd5,
        BLANK2 = 3'd6,
        PAUSE  = 3'd7
    } state_t;

    typedef struct packed {
        logic [47:0] freq;
`ifdef CMD_EXEC_CHIRP_EN
        logic [47:0] step;
        logic [31:0] rate;
        logic [1:0]  typ;
`endif
        logic [63:0] tstart;
        logic [15:0] n;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    state_t      state, state_d;
    logic [31:0] cnt, cnt_d;          // remaining cycles of phase / REQ cycle index
    logic [15:0] imp_cnt, imp_d;
    cmd_t        sh, pend, wr_cmd;
    logic        pend_v, first, late;
    logic [47:0] freq_out;

    logic        trig, phase_last, found, done_all;
    logic [1:0]  cur_ph, nxt_ph;
    logic [15:0] nimp;
    logic        go, end_b, ld_wr, ld_pend, pend_set, pend_clr, ent_pulse;

    function automatic logic [31:0] ph_len(input cmd_t c, input logic [1:0] p);
        case (p)
            2'd0:    return c.tb1;
            2'd1:    return c.ti;
            2'd2:    return c.tb2;
            default: return c.tp;
        endcase
    endfunction

    // Strobed command fields gathered into one record
    always_comb begin
        wr_cmd        = '0;
        wr_cmd.freq   = FREQ;
`ifdef CMD_EXEC_CHIRP_EN
        wr_cmd.step   = FREQ_STEP;
        wr_cmd.rate   = FREQ_RATE;
        wr_cmd.typ    = TYPE_impulse;
`endif
        wr_cmd.tstart = TIME_START;
        wr_cmd.n      = N_impulse;
        wr_cmd.ti     = Interval_Ti;
        wr_cmd.tp     = Interval_Tp;
        wr_cmd.tb1    = Tblank1;
        wr_cmd.tb2    = Tblank2;
    end

`ifndef CMD_EXEC_CHIRP_EN
    logic unused_chirp;
    assign unused_chirp = ^{FREQ_STEP, FREQ_RATE, TYPE_impulse};
`endif

    assign cur_ph     = state[1:0];
    assign trig       = (state == ARMED) && (TIME >= sh.tstart);
    assign phase_last = state[2] && (cnt == 32'd1);

    // Find the next non-empty phase, counting impulses crossed on the way.
    // Zero-length phases are skipped within the same cycle.
    always_comb begin
        found    = 1'b0;
        done_all = 1'b0;
        nxt_ph   = 2'd0;
        nimp     = imp_cnt;
        if (trig) begin
            nimp = '0;
            if (sh.n == 16'd0) done_all = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (!found && !done_all && ph_len(sh, 2'(k)) != 32'd0) begin
                    found  = 1'b1;
                    nxt_ph = 2'(k);
                end
            end
            // every phase is empty: the whole burst completes instantly
            if (!found && !done_all) begin
                nimp     = sh.n;
                done_all = 1'b1;
            end
        end else if (phase_last) begin
            for (int k = 1; k <= 4; k++) begin
                if (!found && !done_all) begin
                    if (int'(cur_ph) + k == 4) begin
                        nimp = nimp + 16'd1;
                        if (nimp == sh.n) done_all = 1'b1;
                    end
                    if (!done_all && ph_len(sh, 2'(int'(cur_ph) + k)) != 32'd0) begin
                        found  = 1'b1;
                        nxt_ph = 2'(int'(cur_ph) + k);
                    end
                end
            end
        end
    end

    // Next-state and load controls
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        imp_d     = imp_cnt;
        go        = 1'b0;
        end_b     = 1'b0;
        ld_wr     = 1'b0;
        ld_pend   = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        ent_pulse = 1'b0;
        case (state)
            IDLE: if (DATA_WR) ld_wr = 1'b1;
            ARMED: begin
                if (DATA_WR) ld_wr = 1'b1;
                else if (trig) begin
                    imp_d = nimp;
                    if (done_all) end_b = 1'b1;
                    else          go    = 1'b1;
                end
            end
            REQ: begin
                if (DATA_WR)                      ld_wr   = 1'b1;
                else if (cnt == 32'(REQ_LEN - 1)) state_d = IDLE;
                else                              cnt_d   = cnt + 32'd1;
            end
            default: begin
                if (phase_last) begin
                    imp_d = nimp;
                    if (done_all) end_b = 1'b1;
                    else          go    = 1'b1;
                end else begin
                    cnt_d = cnt - 32'd1;
                end
                // a strobe on the final burst cycle is taken directly below
                if (DATA_WR && !end_b) pend_set = 1'b1;
            end
        endcase
        if (go) begin
            state_d   = state_t'({1'b1, nxt_ph});
            cnt_d     = ph_len(sh, nxt_ph);
            ent_pulse = (nxt_ph == 2'd1);
        end
        if (end_b) begin
            pend_clr = 1'b1;
            if (DATA_WR)     ld_wr   = 1'b1;
            else if (pend_v) ld_pend = 1'b1;
            else begin
                state_d = REQ;
                cnt_d   = '0;
            end
        end
        if (ld_wr || ld_pend) state_d = ARMED;
    end

    // State, phase counter and impulse counter
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            imp_cnt <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            imp_cnt <= imp_d;
        end
    end

    // Command registers and the sticky LATE flag
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            first  <= 1'b0;
            late   <= 1'b0;
        end else begin
            if (ld_wr)        sh <= wr_cmd;
            else if (ld_pend) sh <= pend;
            if (pend_set) pend <= wr_cmd;
            if (pend_clr)      pend_v <= 1'b0;
            else if (pend_set) pend_v <= 1'b1;
            if (ld_wr || ld_pend)   first <= 1'b1;
            else if (state == ARMED) first <= 1'b0;
            if (DATA_WR) late <= 1'b0;
            else if (state == ARMED && first && TIME > sh.tstart) late <= 1'b1;
        end
    end

`ifdef CMD_EXEC_CHIRP_EN
    logic [31:0] scnt;

    // Frequency word: reload per impulse, sweep inside PULSE, frozen on the
    // last PULSE cycle so the value held outside PULSE is the final one
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            freq_out <= '0;
            scnt     <= '0;
        end else if (ent_pulse) begin
            freq_out <= sh.freq;
            scnt     <= '0;
        end else if (state == PULSE && !phase_last) begin
            if (scnt == sh.rate) begin
                scnt <= '0;
                if (sh.typ == 2'd1)      freq_out <= freq_out + sh.step;
                else if (sh.typ == 2'd2) freq_out <= freq_out - sh.step;
            end else begin
                scnt <= scnt + 32'd1;
            end
        end
    end
`else
    // Frequency word: plain FREQ loaded at the start of every pulse
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)         freq_out <= '0;
        else if (ent_pulse) freq_out <= sh.freq;
    end
`endif

    assign GATE     = (state == PULSE);
    assign BLANK    = (state == BLANK1) || (state == BLANK2);
    assign REQ_COMM = (state == REQ);
    assign BUSY     = (state != IDLE);
    assign LATE     = late;
    assign IMP_CNT  = imp_cnt;
    assign FREQ_OUT = freq_out;

endmodule

// File: tb/tb_cmd_exec_sync.sv
// tb_cmd_exec_sync: directed scenarios plus randomized command traffic, checked
// every cycle against a timeline model that expands each burst into a queue of
// per-cycle output records.
module tb_cmd_exec_sync;

    localparam int REQ_LEN = 4;
    localparam int K_IDLE = 0, K_ARM = 1, K_RUN = 2, K_REQ = 3;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [63:0] TIME;
    logic        DATA_WR;
    logic [47:0] FREQ, FREQ_STEP;
    logic [31:0] FREQ_RATE;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
    logic        GATE, BLANK, REQ_COMM, BUSY, LATE;
    logic [47:0] FREQ_OUT;
    logic [15:0] IMP_CNT;

    cmd_exec_sync #(.REQ_LEN(REQ_LEN)) dut (
        .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .DATA_WR(DATA_WR),
        .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
        .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
        .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
        .Tblank1(Tblank1), .Tblank2(Tblank2),
        .GATE(GATE), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT), .REQ_COMM(REQ_COMM),
        .BUSY(BUSY), .LATE(LATE), .IMP_CNT(IMP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] tstart;
        int          n, typ, tb1, ti, tb2, tp, rate;
        logic [47:0] freq, step;
    } cmd_t;

    typedef struct {
        bit          gate, blank;
        logic [47:0] freq;
        int          imp;
    } rec_t;

    int n_chk = 0, n_err = 0;

    // model
    rec_t        tl[$];
    rec_t        cur;
    cmd_t        m_cmd, m_pend, z;
    int          m_kind, m_req_left, m_imp;
    bit          m_first, m_late, m_pv;
    logic [47:0] m_fexp;

    // observation counters for directed scenarios
    logic [63:0] r_q[$];
    logic [47:0] gq[$];
    int          n_rise, n_req;
    bit          prev_gate;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [63:0] ts, input int n, input int typ,
                                input int tb1, input int ti, input int tb2, input int tp,
                                input logic [47:0] f, input logic [47:0] st, input int rate);
        cmd_t c;
        c.tstart = ts; c.n = n; c.typ = typ; c.tb1 = tb1; c.ti = ti; c.tb2 = tb2;
        c.tp = tp; c.freq = f; c.step = st; c.rate = rate;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        bit   zero = ($urandom_range(0, 7) == 0);
        cmd_t c;
        c.tstart = TIME + 64'($urandom_range(0, 24)) - 64'd4;
        c.n      = $urandom_range(0, 3);
        c.typ    = $urandom_range(0, 3);
        c.tb1    = zero ? 0 : $urandom_range(0, 3);
        c.ti     = zero ? 0 : $urandom_range(0, 6);
        c.tb2    = zero ? 0 : $urandom_range(0, 3);
        c.tp     = zero ? 0 : $urandom_range(0, 3);
        c.freq   = 48'({$urandom, $urandom});
        c.step   = 48'({$urandom_range(0, 15), $urandom});
        c.rate   = $urandom_range(0, 3);
        return c;
    endfunction

    // frequency of pulse cycle j, straight from the sweep rule
    function automatic logic [47:0] fq(input cmd_t c, input int j);
`ifdef CMD_EXEC_CHIRP_EN
        logic [47:0] d = c.step * 48'(j / (c.rate + 1));
        if (c.typ == 1) return c.freq + d;
        if (c.typ == 2) return c.freq - d;
`endif
        return c.freq;
    endfunction

    task automatic build(input cmd_t c);
        tl.delete();
        for (int i = 0; i < c.n; i++) begin
            for (int j = 0; j < c.tb1; j++) tl.push_back('{0, 1, 48'd0, i});
            for (int j = 0; j < c.ti; j++)  tl.push_back('{1, 0, fq(c, j), i});
            for (int j = 0; j < c.tb2; j++) tl.push_back('{0, 1, 48'd0, i});
            for (int j = 0; j < c.tp; j++)  tl.push_back('{0, 0, 48'd0, i});
        end
    endtask

    task automatic pop();
        cur = tl.pop_front();
        if (cur.gate) m_fexp = cur.freq;
    endtask

    task automatic arm(input cmd_t c);
        m_cmd = c; m_kind = K_ARM; m_first = 1;
    endtask

    task automatic finish_burst(input bit wr, input cmd_t c);
        m_imp = m_cmd.n;
        if (wr) begin arm(c); m_pv = 0; end
        else if (m_pv) begin arm(m_pend); m_pv = 0; end
        else begin m_kind = K_REQ; m_req_left = REQ_LEN; end
    endtask

    task automatic model_reset();
        tl.delete();
        m_kind = K_IDLE; m_first = 0; m_late = 0; m_pv = 0; m_imp = 0; m_fexp = '0;
        cur = '{0, 0, 48'd0, 0};
    endtask

    // advance the model by one cycle given this cycle's inputs
    task automatic model_step(input bit wr, input cmd_t c);
        if (wr) m_late = 0;
        else if (m_kind == K_ARM && m_first && TIME > m_cmd.tstart) m_late = 1;
        case (m_kind)
            K_IDLE: if (wr) arm(c);
            K_ARM: begin
                if (wr) arm(c);
                else begin
                    m_first = 0;
                    if (TIME >= m_cmd.tstart) begin
                        m_imp = 0;
                        build(m_cmd);
                        if (tl.size() == 0) finish_burst(0, c);
                        else begin m_kind = K_RUN; pop(); end
                    end
                end
            end
            K_RUN: begin
                if (tl.size() == 0) finish_burst(wr, c);
                else begin
                    if (wr) begin m_pend = c; m_pv = 1; end
                    pop();
                end
            end
            default: begin
                if (wr) arm(c);
                else if (m_req_left == 1) m_kind = K_IDLE;
                else m_req_left--;
            end
        endcase
    endtask

    task automatic compare();
        bit run = (m_kind == K_RUN);
        chk("GATE",     GATE,     run && cur.gate);
        chk("BLANK",    BLANK,    run && cur.blank);
        chk("REQ_COMM", REQ_COMM, m_kind == K_REQ);
        chk("BUSY",     BUSY,     m_kind != K_IDLE);
        chk("LATE",     LATE,     m_late);
        chk("IMP_CNT",  IMP_CNT,  run ? 16'(cur.imp) : 16'(m_imp));
        chk("FREQ_OUT", FREQ_OUT, m_fexp);
    endtask

    task automatic drive(input bit wr, input cmd_t c);
        DATA_WR = wr;
        TIME_START = c.tstart; N_impulse = 16'(c.n); TYPE_impulse = 2'(c.typ);
        Tblank1 = 32'(c.tb1); Interval_Ti = 32'(c.ti); Tblank2 = 32'(c.tb2);
        Interval_Tp = 32'(c.tp); FREQ = c.freq; FREQ_STEP = c.step; FREQ_RATE = 32'(c.rate);
    endtask

    // one clock cycle: new TIME and inputs, check outputs, advance model
    task automatic cyc(input bit wr, input cmd_t c);
        @(negedge CLK);
        TIME = TIME + 64'd1;
        drive(wr, c);
        compare();
        if (GATE && !prev_gate) begin n_rise++; r_q.push_back(TIME); end
        if (GATE) gq.push_back(FREQ_OUT);
        if (REQ_COMM) n_req++;
        prev_gate = GATE;
        model_step(wr, c);
    endtask

    task automatic clr_obs();
        r_q.delete(); gq.delete(); n_rise = 0; n_req = 0;
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 400 && m_kind != K_IDLE; i++) cyc(0, z);
        cyc(0, z);
        chk("idle_BUSY", BUSY, 0);
    endtask

    task automatic wait_gate();
        for (int i = 0; i < 100 && !GATE; i++) cyc(0, z);
        chk("wait_GATE", GATE, 1);
    endtask

    initial begin
        logic [47:0] ch_exp[6];
        logic [63:0] ts;
        z = mk(0, 0, 0, 0, 0, 0, 0, 48'd0, 48'd0, 0);
        prev_gate = 0;
        clr_obs();
        model_reset();
        rst_n = 1'b0; TIME = '0;
        drive(0, z);
        repeat (3) @(negedge CLK);
        chk("rst_GATE", GATE, 0);     chk("rst_BLANK", BLANK, 0);
        chk("rst_REQ", REQ_COMM, 0);  chk("rst_BUSY", BUSY, 0);
        chk("rst_LATE", LATE, 0);     chk("rst_IMP", IMP_CNT, 0);
        chk("rst_FREQ", FREQ_OUT, 0);
        rst_n = 1'b1;

        // tone burst
        TIME = 64'd99;
        clr_obs();
        cyc(1, mk(120, 2, 0, 2, 5, 1, 3, 48'd777, 48'd0, 0));
        idle_wait();
        chk("tone_rise0", (r_q.size() > 0) ? r_q[0] : 64'd0, 64'd123);
        chk("tone_rise1", (r_q.size() > 1) ? r_q[1] : 64'd0, 64'd134);
        chk("tone_nrise", n_rise, 2);
        chk("tone_ngate", gq.size(), 10);
        chk("tone_nreq", n_req, REQ_LEN);
        chk("tone_imp", IMP_CNT, 2);

        // chirp up
`ifdef CMD_EXEC_CHIRP_EN
        ch_exp = '{48'd1000, 48'd1000, 48'd1010, 48'd1010, 48'd1020, 48'd1020};
`else
        ch_exp = '{48'd1000, 48'd1000, 48'd1000, 48'd1000, 48'd1000, 48'd1000};
`endif
        clr_obs();
        cyc(1, mk(TIME + 3, 1, 1, 0, 6, 0, 0, 48'd1000, 48'd10, 1));
        idle_wait();
        chk("chirp_n", gq.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("chirp_f%0d", i), (gq.size() > i) ? gq[i] : 48'd0, ch_exp[i]);
        chk("chirp_hold", FREQ_OUT, ch_exp[5]);

        // chirp down wrap
        clr_obs();
        cyc(1, mk(TIME + 3, 1, 2, 0, 2, 0, 0, 48'd5, 48'd10, 0));
        idle_wait();
`ifdef CMD_EXEC_CHIRP_EN
        chk("wrap_f1", (gq.size() > 1) ? gq[1] : 48'd0, 48'hFFFF_FFFF_FFFB);
`else
        chk("wrap_f1", (gq.size() > 1) ? gq[1] : 48'd0, 48'd5);
`endif

        // late start
        cyc(1, mk(TIME - 20, 1, 0, 0, 2, 0, 0, 48'd42, 48'd0, 0));
        cyc(0, z);
        cyc(0, z);
        chk("late_LATE", LATE, 1);
        chk("late_GATE", GATE, 1);
        idle_wait();

        // N=0
        clr_obs();
        cyc(1, mk(TIME + 2, 0, 0, 1, 3, 1, 1, 48'd9, 48'd0, 0));
        idle_wait();
        chk("n0_rise", n_rise, 0);
        chk("n0_req", n_req, REQ_LEN);

        // all phases zero
        clr_obs();
        cyc(1, mk(TIME + 2, 3, 0, 0, 0, 0, 0, 48'd9, 48'd0, 0));
        idle_wait();
        chk("zero_imp", IMP_CNT, 3);
        chk("zero_rise", n_rise, 0);
        chk("zero_req", n_req, REQ_LEN);

        // re-arm replaces the armed command
        clr_obs();
        cyc(1, mk(TIME + 200, 1, 0, 0, 3, 0, 0, 48'd1, 48'd0, 0));
        repeat (3) cyc(0, z);
        ts = TIME + 11;
        cyc(1, mk(ts, 1, 0, 0, 3, 0, 0, 48'd2, 48'd0, 0));
        idle_wait();
        chk("rearm_rise", n_rise, 1);
        chk("rearm_t", (r_q.size() > 0) ? r_q[0] : 64'd0, ts + 64'd1);

        // pending command during PULSE
        clr_obs();
        cyc(1, mk(TIME + 3, 1, 0, 1, 4, 1, 1, 48'd3, 48'd0, 0));
        wait_gate();
        cyc(1, mk(TIME + 30, 1, 0, 0, 2, 0, 0, 48'd4, 48'd0, 0));
        idle_wait();
        chk("pend_rise", n_rise, 2);
        chk("pend_req", n_req, REQ_LEN);

        // asynchronous reset in the middle of a pulse
        cyc(1, mk(TIME + 4, 2, 0, 1, 8, 1, 2, 48'h123, 48'd0, 0));
        wait_gate();
        cyc(0, z);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_GATE", GATE, 0);  chk("arst_BLANK", BLANK, 0);
        chk("arst_REQ", REQ_COMM, 0); chk("arst_BUSY", BUSY, 0);
        chk("arst_FREQ", FREQ_OUT, 0);
        model_reset();
        @(negedge CLK);
        rst_n = 1'b1;
        prev_gate = 0;

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            bit wr = (m_kind == K_IDLE) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 29) == 0);
            cyc(wr, wr ? rnd_cmd() : z);
        end
        idle_wait();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
